// File: rtl/axi_lite_ctrl_regs.sv
// axi_lite_ctrl_regs: AXI4-Lite control/status register file for the HDC accelerator.
// Define HPU_PERF_COUNTER_EN to add the run-time cycle counter (CYC word).
module axi_lite_ctrl_regs #(
    parameter int ADDR_W = 12,
    parameter int NREG   = 4,
    parameter int NSTAT  = 4
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [32*NREG-1:0]    ctrl_o,
    output logic                  run,
    output logic                  com,
    input  logic [32*NSTAT-1:0]   stat_i,
    input  logic                  done_i,
    output logic                  irq
);

    localparam int IW     = ADDR_W - 2;
    localparam int SR_IDX = NREG + NSTAT;
`ifdef HPU_PERF_COUNTER_EN
    localparam int LAST_IDX = SR_IDX + 1;
`else
    localparam int LAST_IDX = SR_IDX;
`endif

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_COMMIT,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_RESP
    } r_state_t;

    w_state_t        w_state;
    w_state_t        w_next;
    r_state_t        r_state;
    r_state_t        r_next;

    logic            aw_take;
    logic            w_take;
    logic            ar_take;
    logic            commit;
    logic            wr_err;

    logic [IW-1:0]   wr_idx;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic [1:0]      bresp;

    logic [IW-1:0]   rd_idx;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic [31:0]     rd_data;
    logic            rd_err;

    logic [31:0]     ctrl_q [NREG];
    logic [31:0]     ctrl_d [NREG];
    logic            done_q;
    logic            done_d;
    logic            irq_en_q;
    logic            irq_en_d;
    logic            irq_q;

    logic            unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies are gated so every output is low while reset is held
    assign S_AXI_AWREADY = S_AXI_ARESETN &&
                           (w_state == W_IDLE || w_state == W_DATA);
    assign S_AXI_WREADY  = S_AXI_ARESETN &&
                           (w_state == W_IDLE || w_state == W_ADDR);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = S_AXI_ARESETN && (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_RESP);
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;

    assign run    = ctrl_q[0][0];
    assign com    = ctrl_q[0][1];
    assign irq    = irq_q;
    assign commit = (w_state == W_COMMIT);
    assign wr_err = (wr_idx > IW'(LAST_IDX));

    for (genvar k = 0; k < NREG; k++) begin : g_ctrl
        assign ctrl_o[32*k +: 32] = ctrl_q[k];
    end

    always_comb begin
        w_next  = w_state;
        aw_take = 1'b0;
        w_take  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    aw_take = 1'b1;
                    w_take  = 1'b1;
                    w_next  = W_COMMIT;
                end else if (S_AXI_AWVALID) begin
                    aw_take = 1'b1;
                    w_next  = W_ADDR;
                end else if (S_AXI_WVALID) begin
                    w_take  = 1'b1;
                    w_next  = W_DATA;
                end
            end
            W_ADDR: begin
                if (S_AXI_WVALID) begin
                    w_take = 1'b1;
                    w_next = W_COMMIT;
                end
            end
            W_DATA: begin
                if (S_AXI_AWVALID) begin
                    aw_take = 1'b1;
                    w_next  = W_COMMIT;
                end
            end
            W_COMMIT: w_next = W_RESP;
            W_RESP: begin
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            wr_idx  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            bresp   <= 2'b00;
        end else begin
            w_state <= w_next;
            if (aw_take) wr_idx <= S_AXI_AWADDR[ADDR_W-1:2];
            if (w_take) begin
                wdata <= S_AXI_WDATA;
                wstrb <= S_AXI_WSTRB;
            end
            if (commit) bresp <= wr_err ? 2'b10 : 2'b00;
        end
    end

    always_comb begin
        for (int k = 0; k < NREG; k++) ctrl_d[k] = ctrl_q[k];
        done_d   = done_q;
        irq_en_d = irq_en_q;
        if (commit) begin
            for (int k = 0; k < NREG; k++) begin
                if (wr_idx == IW'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) ctrl_d[k][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
            if (wr_idx == IW'(SR_IDX) && wstrb[0]) begin
                if (wdata[0]) done_d = 1'b0;
                irq_en_d = wdata[1];
            end
        end
        // Completion overrides a same-edge W1C of done and a write of run
        if (done_i) begin
            done_d = 1'b1;
            if (ctrl_q[0][2]) ctrl_d[0][0] = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NREG; k++) ctrl_q[k] <= '0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NREG; k++) ctrl_q[k] <= ctrl_d[k];
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            irq_q    <= done_q & irq_en_q;
        end
    end

`ifdef HPU_PERF_COUNTER_EN
    logic [31:0] cyc_q;

    // Cleared on the edge where run rises, then counts cycles spent with run high
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cyc_q <= '0;
        end else if (ctrl_d[0][0] && !ctrl_q[0][0]) begin
            cyc_q <= '0;
        end else if (ctrl_q[0][0] && cyc_q != 32'hFFFF_FFFF) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int k = 0; k < NREG; k++) begin
            if (rd_idx == IW'(k)) begin
                rd_data = ctrl_q[k];
                rd_err  = 1'b0;
            end
        end
        for (int k = 0; k < NSTAT; k++) begin
            if (rd_idx == IW'(NREG + k)) begin
                rd_data = stat_i[32*k +: 32];
                rd_err  = 1'b0;
            end
        end
        if (rd_idx == IW'(SR_IDX)) begin
            rd_data = {23'd0, ctrl_q[0][0], 6'd0, irq_en_q, done_q};
            rd_err  = 1'b0;
        end
`ifdef HPU_PERF_COUNTER_EN
        if (rd_idx == IW'(SR_IDX + 1)) begin
            rd_data = cyc_q;
            rd_err  = 1'b0;
        end
`endif
    end

    always_comb begin
        r_next  = r_state;
        ar_take = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    ar_take = 1'b1;
                    r_next  = R_FETCH;
                end
            end
            R_FETCH: r_next = R_RESP;
            R_RESP: begin
                if (S_AXI_RREADY) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= R_IDLE;
            rd_idx  <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            r_state <= r_next;
            if (ar_take) rd_idx <= S_AXI_ARADDR[ADDR_W-1:2];
            if (r_state == R_FETCH) begin
                rdata <= rd_data;
                rresp <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// tb_axi_lite_ctrl_regs: randomized bench with a word-level register model.
// Define HPU_PERF_COUNTER_EN for both RTL and bench to cover the CYC word.
module tb_axi_lite_ctrl_regs;

    localparam int ADDR_W  = 12;
    localparam int NREG    = 4;
    localparam int NSTAT   = 4;
    localparam int SR_IDX  = NREG + NSTAT;
    localparam int CYC_IDX = SR_IDX + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [ADDR_W-1:0]    AWADDR = '0;
    logic                 AWVALID = 1'b0;
    logic                 AWREADY;
    logic [31:0]          WDATA = '0;
    logic [3:0]           WSTRB = '0;
    logic                 WVALID = 1'b0;
    logic                 WREADY;
    logic [1:0]           BRESP;
    logic                 BVALID;
    logic                 BREADY = 1'b0;
    logic [ADDR_W-1:0]    ARADDR = '0;
    logic                 ARVALID = 1'b0;
    logic                 ARREADY;
    logic [31:0]          RDATA;
    logic [1:0]           RRESP;
    logic                 RVALID;
    logic                 RREADY = 1'b0;
    logic [32*NREG-1:0]   ctrl_o;
    logic                 run;
    logic                 com;
    logic [32*NSTAT-1:0]  stat_v = '0;
    logic                 done_i = 1'b0;
    logic                 irq;

    axi_lite_ctrl_regs #(.ADDR_W(ADDR_W), .NREG(NREG), .NSTAT(NSTAT)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID),
        .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID),
        .S_AXI_RREADY(RREADY),
        .ctrl_o(ctrl_o), .run(run), .com(com), .stat_i(stat_v),
        .done_i(done_i), .irq(irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_ctrl [NREG];
    logic        m_done;
    logic        m_irq_en;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int k = 0; k < NREG; k++) m_ctrl[k] = '0;
        m_done   = 1'b0;
        m_irq_en = 1'b0;
    endfunction

    function automatic logic [1:0] m_write(input logic [ADDR_W-1:0] a,
                                           input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a >> 2);
        if (idx < NREG) begin
            for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[idx][8*b +: 8] = d[8*b +: 8];
            return 2'b00;
        end
        if (idx < SR_IDX) return 2'b00;
        if (idx == SR_IDX) begin
            if (s[0]) begin
                if (d[0]) m_done = 1'b0;
                m_irq_en = d[1];
            end
            return 2'b00;
        end
`ifdef HPU_PERF_COUNTER_EN
        if (idx == CYC_IDX) return 2'b00;
`endif
        return 2'b10;
    endfunction

    function automatic void m_read(input logic [ADDR_W-1:0] a,
                                   output logic [31:0] d, output logic [1:0] r);
        int idx = int'(a >> 2);
        d = '0;
        r = 2'b10;
        if (idx < NREG) begin
            d = m_ctrl[idx];
            r = 2'b00;
        end else if (idx < SR_IDX) begin
            d = stat_v[32*(idx-NREG) +: 32];
            r = 2'b00;
        end else if (idx == SR_IDX) begin
            d[0] = m_done;
            d[1] = m_irq_en;
            d[8] = m_ctrl[0][0];
            r = 2'b00;
        end
    endfunction

    function automatic void m_done_pulse(input logic auto_stop);
        m_done = 1'b1;
        if (auto_stop) m_ctrl[0][0] = 1'b0;
    endfunction

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
    task automatic axi_write(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead, input bit pulse,
                             output int unsigned acc);
        int aw_at, w_at, n, lat;
        bit aw_ok, w_ok, aw_go, w_go;
        logic pre_auto;
        logic [1:0] exp_r, got_r;
        aw_at = lead > 0 ? lead : 0;
        w_at  = lead < 0 ? -lead : 0;
        aw_ok = 0; w_ok = 0; n = 0; acc = 0;
        while (!(aw_ok && w_ok) && n < 40) begin
            if (!aw_ok && n >= aw_at) begin AWADDR = a; AWVALID = 1'b1; end
            if (!w_ok && n >= w_at) begin WDATA = d; WSTRB = s; WVALID = 1'b1; end
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            tick();
            n++;
            if (aw_go) begin aw_ok = 1; AWVALID = 1'b0; end
            if (w_go) begin w_ok = 1; WVALID = 1'b0; end
        end
        if (!(aw_ok && w_ok)) begin
            chk("wr_accept_timeout", 1, 0);
            AWVALID = 1'b0;
            WVALID = 1'b0;
            return;
        end
        acc = cyc_n;
        pre_auto = m_ctrl[0][2];
        if (pulse) done_i = 1'b1;
        exp_r = m_write(a, d, s);
        if (pulse) m_done_pulse(pre_auto);
        lat = 0;
        while (!BVALID && lat < 20) begin
            tick();
            done_i = 1'b0;
            lat++;
        end
        done_i = 1'b0;
        chk("b_latency", lat, 1);
        got_r = BRESP;
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("bvalid_hold", BVALID, 1);
            chk("bresp_hold", BRESP, got_r);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("bresp", got_r, exp_r);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output int unsigned acc);
        int n, lat;
        ARADDR = a;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin tick(); n++; end
        if (n >= 20) chk("ar_accept_timeout", 1, 0);
        tick();
        ARVALID = 1'b0;
        acc = cyc_n;
        lat = 0;
        while (!RVALID && lat < 20) begin tick(); lat++; end
        chk("r_latency", lat, 1);
        data = RDATA;
        resp = RRESP;
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("rdata_hold", RDATA, data);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic read_check(input logic [ADDR_W-1:0] a, input string tag);
        logic [31:0] got_d, exp_d;
        logic [1:0]  got_r, exp_r;
        int unsigned acc;
        stat_v = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_read(a, exp_d, exp_r);
        axi_read(a, got_d, got_r, acc);
        chk({tag, "_data"}, got_d, exp_d);
        chk({tag, "_resp"}, got_r, exp_r);
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NREG; k++) chk("ctrl_o", ctrl_o[32*k +: 32], m_ctrl[k]);
        chk("run", run, m_ctrl[0][0]);
        chk("com", com, m_ctrl[0][1]);
        chk("irq", irq, m_done & m_irq_en);
    endtask

    task automatic pulse_done();
        logic pre_auto;
        logic irq_before;
        pre_auto = m_ctrl[0][2];
        irq_before = m_done & m_irq_en;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        m_done_pulse(pre_auto);
        chk("run_after_done", run, m_ctrl[0][0]);
        chk("irq_delay", irq, irq_before);
        tick();
        chk("irq_follow", irq, m_done & m_irq_en);
    endtask

    function automatic int pick_idx();
        int r = int'($urandom_range(0, SR_IDX + 3));
        return (r == SR_IDX + 3) ? 1020 : r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int unsigned acc1, acc2, acc3, acc_r;
        m_reset();
        repeat (3) tick();
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_ctrl_o", ctrl_o[63:0], 0);
        chk("rst_irq", irq, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_awready", AWREADY, 1);
        chk("post_rst_wready", WREADY, 1);
        chk("post_rst_arready", ARREADY, 1);
        tick();

        axi_write(12'h000, 32'h0000_0003, 4'hF, 0, 0, acc1);
        chk("run_set", run, 1);
        chk("com_set", com, 1);
        check_outputs();

        axi_write(12'h004, 32'hAABB_CCDD, 4'b0101, 3, 0, acc1);
        read_check(12'h004, "ctrl1_strb");
        chk("ctrl1_value", ctrl_o[63:32], 32'h00BB_00DD);

        axi_write(12'h000, 32'h0000_0007, 4'hF, 0, 0, acc1);
        axi_write(ADDR_W'(SR_IDX*4), 32'h2, 4'h1, -2, 0, acc1);
        pulse_done();
        chk("autostop_run", run, 0);
        stat_v = '0;
        axi_read(ADDR_W'(SR_IDX*4), d, r, acc_r);
        chk("sr_after_done", d, 32'h3);
        chk("sr_irq", irq, 1);
        axi_write(ADDR_W'(SR_IDX*4), 32'h3, 4'h1, 0, 0, acc1);
        check_outputs();

        axi_write(ADDR_W'(SR_IDX*4), 32'h3, 4'h1, 0, 1, acc1);
        axi_read(ADDR_W'(SR_IDX*4), d, r, acc_r);
        chk("done_set_wins", d[0], 1);
        check_outputs();

        axi_write(12'h000, 32'h0000_0005, 4'hF, 0, 1, acc1);
        chk("autostop_over_write", run, 0);
        check_outputs();

        read_check(12'hFF0, "unmapped_rd");
        axi_write(12'hFF0, 32'hFFFF_FFFF, 4'hF, 1, 0, acc1);
        check_outputs();

`ifdef HPU_PERF_COUNTER_EN
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, acc1);
        axi_write(12'h000, 32'h1, 4'hF, 0, 0, acc1);
        while (cyc_n < acc1 + 99) tick();
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, acc2);
        repeat (5) tick();
        axi_read(ADDR_W'(CYC_IDX*4), d, r, acc_r);
        chk("cyc_count", d, acc2 - acc1);
        chk("cyc_resp", r, 0);
        axi_write(12'h000, 32'h1, 4'hF, 0, 0, acc3);
        axi_read(ADDR_W'(CYC_IDX*4), d, r, acc_r);
        chk("cyc_restart", d, acc_r - acc3 - 1);
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, acc1);
        check_outputs();
`else
        read_check(ADDR_W'(CYC_IDX*4), "cyc_unmapped");
`endif

        for (int i = 0; i < 200; i++) begin
            int op = int'($urandom_range(0, 9));
            int idx = pick_idx();
            logic [ADDR_W-1:0] a = ADDR_W'(idx * 4 + int'($urandom_range(0, 3)));
            if (op <= 3) begin
                logic [3:0] s = 4'($urandom_range(0, 15));
                bit pl = ($urandom_range(0, 4) == 0) && !(idx == 0 && s[0]);
                axi_write(a, $urandom(), s, int'($urandom_range(0, 6)) - 3, pl, acc1);
                check_outputs();
            end else if (op <= 6) begin
`ifdef HPU_PERF_COUNTER_EN
                if (idx == CYC_IDX) a = ADDR_W'(SR_IDX * 4);
`endif
                read_check(a, "rand_rd");
            end else if (op == 7) begin
                pulse_done();
                check_outputs();
            end else begin
                repeat ($urandom_range(0, 3)) tick();
            end
        end

        AWADDR = 12'h004;
        AWVALID = 1'b1;
        WDATA = 32'h1234_5678;
        WSTRB = 4'hF;
        WVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_bvalid", BVALID, 0);
        chk("abort_awready", AWREADY, 0);
        tick();
        tick();
        chk("abort_ctrl1", ctrl_o[63:32], 0);
        rst_n = 1'b1;
        m_reset();
        #1;
        chk("abort_awready_back", AWREADY, 1);
        tick();
        check_outputs();
        read_check(12'h004, "abort_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_ctrl_regs.md
# axi_lite_ctrl_regs

Parametrised AXI4-Lite control/status register file for the HDC accelerator, replacing the fixed two-bit `{com, run}` register decode in the top level. It provides NREG byte-strobed control words, NSTAT read-only status words, a sticky done flag with interrupt, optional auto-stop of `run`, and an optional run-time cycle counter. Read and write channels run independent state machines, and unmapped accesses return SLVERR. It sits between the PS AXI-Lite master and the accelerator mode/control inputs.

## Interface

Parameters:
- `ADDR_W`, default 12. Byte address width; word index is `addr[ADDR_W-1:2]`.
- `NREG`, default 4. Number of read/write control words, minimum 1. Word 0 holds the mode bits.
- `NSTAT`, default 4. Number of read-only status words sampled from `stat_i`.

Ports:
- `S_AXI_ACLK`  in  1  Single clock for all logic.
- `S_AXI_ARESETN`  in  1  Asynchronous, active-low reset.
- `S_AXI_AWADDR` in ADDR_W, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1  Write address channel.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1  Write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1  Write response channel.
- `S_AXI_ARADDR` in ADDR_W, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1  Read address channel.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1  Read data channel.
- `ctrl_o`  out  32*NREG  Flattened control words; word k is at `[32k+31:32k]`.
- `run`  out 1  Equals CTRL0 bit 0.
- `com`  out 1  Equals CTRL0 bit 1.
- `stat_i`  in  32*NSTAT  Status words, sampled at read fetch.
- `done_i`  in  1  Single-cycle pulse when the last output beat is transferred.
- `irq`  out  1  Registered output: `done & irq_en`.

## Operation

Address map, by word index:
- 0 .. NREG-1: CTRL, read/write. CTRL0 bit 0 = run, bit 1 = com, bit 2 = auto_stop.
- NREG .. NREG+NSTAT-1: STAT, read-only.
- NREG+NSTAT: SR.
  - bit 0: done, sticky, write-1-to-clear.
  - bit 1: irq_en, read/write.
  - bit 8: run mirror, read-only.
- NREG+NSTAT+1: CYC (only when the feature is enabled).
- Any other index is unmapped: writes are ignored, reads return 0, and the response is 2'b10 (SLVERR). All mapped accesses respond 2'b00.
- A write to a read-only word is ignored but still responds OKAY.

Write FSM states: W_IDLE, W_ADDR, W_DATA, W_COMMIT, W_RESP.
- W_IDLE (AWREADY=1, WREADY=1):
  - AW and W both valid → W_COMMIT.
  - AW only → W_ADDR.
  - W only → W_DATA.
- W_ADDR (WREADY=1): on WVALID → W_COMMIT.
- W_DATA (AWREADY=1): on AWVALID → W_COMMIT.
- W_COMMIT lasts one cycle. At the end of this cycle:
  - The addressed CTRL/SR bits are updated, per WSTRB byte lane.
  - SR W1C and irq_en use lane 0 only.
  - The FSM moves to W_RESP.
- W_RESP: BVALID=1 and BRESP held stable until BREADY, then → W_IDLE.

Read FSM states: R_IDLE, R_FETCH, R_RESP.
- R_IDLE (ARREADY=1): on ARVALID, capture the address → R_FETCH.
- R_FETCH: RDATA and RRESP are registered → R_RESP.
- R_RESP: RVALID=1, data held until RREADY, then → R_IDLE.

Sticky done, auto-stop and precedence:
- `done_i` sets done.
- If auto_stop=1, `done_i` also clears run in the same edge.
- If a `done_i` set and a W1C clear land on the same edge, set wins.
- If a CTRL0 write and an auto-stop clear land on the same edge, auto-stop wins for bit 0 only.

## Timing

- While ARESETN is low, every output is 0: READYs, VALIDs, RESPs, RDATA, `ctrl_o`, `run`, `com`, `irq`, CYC. The first cycle after release has AWREADY=WREADY=ARREADY=1.
- Write latency:
  - The last of AW/W is accepted at edge n.
  - The register is updated at edge n+1.
  - BVALID is high from cycle n+2.
- Read latency: AR accepted at edge n → RVALID high from cycle n+2.
- The write and read FSMs run concurrently. If a read's R_FETCH cycle coincides with a W_COMMIT to the same word, the read returns the pre-write value.
- `irq` follows a done set by exactly one cycle.
- Reset asserted mid-transaction aborts both FSMs immediately with no response; no partial write is applied.

## Configuration

- `HPU_PERF_COUNTER_EN` defined:
  - CYC is a 32-bit counter.
  - It is cleared on the 0→1 edge of run.
  - It increments each cycle while run=1 and saturates at 0xFFFFFFFF.
  - It holds its value while run=0.
- Not defined: no counter logic exists, and index NREG+NSTAT+1 is unmapped (reads 0 with SLVERR).

## Test plan

- Reset, then write 0x00000003 to byte address 0x0 with AW and W in the same cycle → `run=1`, `com=1`; BVALID 2 cycles after acceptance; BRESP=0.
- W presented 3 cycles before AW, data 0xAABBCCDD, WSTRB=4'b0101, to CTRL1 (previously 0) → CTRL1 reads 0x00BB00DD with RRESP=0.
- Set irq_en and auto_stop, set run, then pulse `done_i` → run=0 on the next edge, SR reads 0x003 (done and irq_en set, run mirror 0), `irq=1`. Then write SR=0x3 → done=0, irq=0.
- `done_i` pulse on the same edge as the SR W1C commit → done remains 1.
- Read byte address 0xFF0 → RDATA=0, RRESP=2'b10. Write to the same address → BRESP=2'b10, and no register changes.
- With `HPU_PERF_COUNTER_EN`: set run and hold for 100 cycles, clear run, read CYC → 100. Set run again → CYC restarts from 0.
